// File: rtl/dmem_block_engine.sv
// dmem_block_engine: bus-master block engine on the data-memory port.
// Copies, fills or checksums a block of 32-bit words using a synchronous-read
// memory (read issued in cycle k returns data in cycle k+1).
module dmem_block_engine #(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int          COUNT_BITS         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [COUNT_BITS-1:0] count,
  input  logic [31:0]           fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum,
  output logic [31:0]           dAddress,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           dWriteData,
  input  logic [31:0]           dReadData
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CP_RD    = 3'd1,
    S_CP_WR    = 3'd2,
    S_FL_WR    = 3'd3,
    S_SM_RD    = 3'd4,
    S_SM_DRAIN = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [COUNT_BITS-1:0] CNT_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_BITS-1:0] CNT_ZERO = {COUNT_BITS{1'b0}};

  state_t                  r_state;
  state_t                  w_next_state;
  logic [31:0]             r_src;
  logic [31:0]             r_dst;
  logic [COUNT_BITS-1:0]   r_cnt;
  logic [31:0]             r_fill;
  logic [31:0]             r_checksum;
  logic                    r_error;
  logic                    r_acc;      // dReadData this cycle belongs to a checksum read
  logic                    r_busy;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_cmd_err;
  logic                    w_last;
  logic                    w_mem_rd;
  logic                    w_mem_wr;
  logic [31:0]             w_addr;
  logic [31:0]             w_wdata;
  logic                    w_unused;

  // The base address parameter is informational for integrators; it has no role in the datapath.
  assign w_unused = ^DATA_START_ADDRESS;

  assign w_last = (r_cnt == CNT_ONE);

  // Command legality: reserved mode or a misaligned active address is an error.
  always_comb begin
    w_cmd_err = 1'b0;
    case (mode)
      2'd0:    w_cmd_err = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
      2'd1:    w_cmd_err = (dst_addr[1:0] != 2'b00);
      2'd2:    w_cmd_err = (src_addr[1:0] != 2'b00);
      default: w_cmd_err = 1'b1;
    endcase
  end

  // Next-state logic; a start is honoured in IDLE and in the DONE cycle.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_cmd_err || (count == CNT_ZERO)) begin
            w_next_state = S_DONE;
          end else begin
            case (mode)
              2'd0:    w_next_state = S_CP_RD;
              2'd1:    w_next_state = S_FL_WR;
              2'd2:    w_next_state = S_SM_RD;
              default: w_next_state = S_DONE;
            endcase
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CP_RD: w_next_state = S_CP_WR;
      S_CP_WR: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_CP_RD;
        end
      end
      S_FL_WR: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FL_WR;
        end
      end
      S_SM_RD: begin
        if (w_last) begin
          w_next_state = S_SM_DRAIN;
        end else begin
          w_next_state = S_SM_RD;
        end
      end
      S_SM_DRAIN: w_next_state = S_DONE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Memory port decode from registered state; copy write data passes dReadData straight through.
  always_comb begin
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_addr   = 32'h0000_0000;
    w_wdata  = 32'h0000_0000;
    case (r_state)
      S_CP_RD: begin
        w_mem_rd = 1'b1;
        w_addr   = r_src;
      end
      S_CP_WR: begin
        w_mem_wr = 1'b1;
        w_addr   = r_dst;
        w_wdata  = dReadData;
      end
      S_FL_WR: begin
        w_mem_wr = 1'b1;
        w_addr   = r_dst;
        w_wdata  = r_fill;
      end
      S_SM_RD: begin
        w_mem_rd = 1'b1;
        w_addr   = r_src;
      end
      default: begin
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
      end
    endcase
  end

  // State register plus busy/done flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Operand capture, address/count stepping and checksum accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src      <= 32'h0000_0000;
      r_dst      <= 32'h0000_0000;
      r_cnt      <= CNT_ZERO;
      r_fill     <= 32'h0000_0000;
      r_checksum <= 32'h0000_0000;
      r_error    <= 1'b0;
      r_acc      <= 1'b0;
    end else if (w_accept) begin
      r_src      <= src_addr;
      r_dst      <= dst_addr;
      r_cnt      <= count;
      r_fill     <= fill_value;
      r_checksum <= 32'h0000_0000;
      r_error    <= w_cmd_err;
      r_acc      <= 1'b0;
    end else begin
      case (r_state)
        S_CP_WR: begin
          r_src <= r_src + 32'd4;
          r_dst <= r_dst + 32'd4;
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_FL_WR: begin
          r_dst <= r_dst + 32'd4;
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_SM_RD: begin
          r_src <= r_src + 32'd4;
          r_cnt <= r_cnt - CNT_ONE;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
      r_acc <= (r_state == S_SM_RD);
      if (r_acc) begin
        r_checksum <= r_checksum + dReadData;
      end else begin
        r_checksum <= r_checksum;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign checksum   = r_checksum;
  assign dAddress   = w_addr;
  assign MemRead    = w_mem_rd;
  assign MemWrite   = w_mem_wr;
  assign dWriteData = w_wdata;

endmodule
